mux: RTL and testbench

MUX -- requirements
Module: mux

---
 rtl/mux.sv | 36 +++
 tb/tb_mux.sv | 116 +++++++++++
 2 files changed

// File: rtl/mux.sv
// mux: N_IN:1 bit multiplexer with registered output, select and select-change flag
module mux #(
   parameter int N_IN  = 8,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IN-1:0]  in,
   input  logic [SEL_W-1:0] sel,
   output logic             out,
   output logic             out_q,
   output logic [SEL_W-1:0] sel_q,
   output logic             sel_chg
);
   logic             w_out;
   logic             r_out_q;
   logic [SEL_W-1:0] r_sel_q;
   logic             r_sel_chg;
   assign w_out   = in[sel];
   assign out     = w_out;
   assign out_q   = r_out_q;
   assign sel_q   = r_sel_q;
   assign sel_chg = r_sel_chg;
   // register the selected bit and select; flag a select that differs from last cycle's
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_q   <= 1'b0;
         r_sel_q   <= '0;
         r_sel_chg <= 1'b0;
      end else begin
         r_out_q   <= w_out;
         r_sel_q   <= sel;
         r_sel_chg <= sel != r_sel_q;
      end
   end
endmodule

// File: tb/tb_mux.sv
// tb_mux: randomized and directed self-checking bench for mux
module tb_mux;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in  = 8'h00;
   logic [2:0] sel = 3'd0;
   logic       out, out_q, sel_chg;
   logic [2:0] sel_q;
   int checks = 0;
   int errors = 0;
   bit         m_valid = 1'b0;
   logic       m_out_q;
   logic [2:0] m_sel_q;
   logic       m_chg;
   logic [2:0] prev_sel;
   logic [7:0] tbl;

   mux #(.N_IN(8), .SEL_W(3)) dut (
      .clk(clk), .rst(rst), .in(in), .sel(sel),
      .out(out), .out_q(out_q), .sel_q(sel_q), .sel_chg(sel_chg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference: the registered outputs capture the selected bit and the select seen at each edge
   always @(posedge clk) begin
      if (rst) begin
         m_valid  = 1'b1;
         prev_sel = 3'd0;
         m_out_q  = 1'b0;
         m_sel_q  = 3'd0;
         m_chg    = 1'b0;
      end else begin
         m_chg    = (sel != prev_sel);
         m_out_q  = (in >> sel) & 8'h01;
         m_sel_q  = sel;
         prev_sel = sel;
      end
   end

   // every cycle once reset has been seen: compare DUT against the reference
   always @(negedge clk) begin
      if (m_valid) begin
         chk("out", {31'b0, out}, {31'b0, (in >> sel) & 8'h01});
         chk("out_q", {31'b0, out_q}, {31'b0, m_out_q});
         chk("sel_q", {29'b0, sel_q}, {29'b0, m_sel_q});
         chk("sel_chg", {31'b0, sel_chg}, {31'b0, m_chg});
      end
   end

   initial begin
      tick();
      tick();
      chk("rst_out_q", {31'b0, out_q}, 0);
      chk("rst_sel_q", {29'b0, sel_q}, 0);
      chk("rst_sel_chg", {31'b0, sel_chg}, 0);
      in = 8'b10001010; sel = 3'b010;
      #5 chk("comb_sel2", {31'b0, out}, 0);
      tick();
      sel = 3'b111;
      #5 chk("comb_sel7", {31'b0, out}, 1);
      tick();
      tbl = 8'b10001010;
      for (int s = 0; s < 8; s++) begin
         sel = s[2:0];
         #1 chk("sweep", {31'b0, out}, {31'b0, tbl[s]});
      end
      tick();
      rst = 1'b0; in = 8'hFF; sel = 3'd5;
      #1 chk("lat_out", {31'b0, out}, 1);
      tick();
      chk("lat_out_q", {31'b0, out_q}, 1);
      chk("lat_sel_q", {29'b0, sel_q}, 5);
      chk("lat_chg1", {31'b0, sel_chg}, 1);
      tick();
      chk("lat_chg0", {31'b0, sel_chg}, 0);
      rst = 1'b1;
      tick();
      chk("mid_rst_out_q", {31'b0, out_q}, 0);
      chk("mid_rst_sel_q", {29'b0, sel_q}, 0);
      chk("mid_rst_chg", {31'b0, sel_chg}, 0);
      chk("mid_rst_out", {31'b0, out}, 1);
      rst = 1'b0; sel = 3'd3; in = 8'h00;
      tick();
      tick();
      in = 8'h08;
      #1 chk("data_out", {31'b0, out}, 1);
      chk("data_out_q_old", {31'b0, out_q}, 0);
      tick();
      chk("data_out_q_new", {31'b0, out_q}, 1);
      chk("data_chg", {31'b0, sel_chg}, 0);
      for (int i = 0; i < 400; i++) begin
         in  = 8'($urandom);
         if ($urandom_range(1, 0) == 1) sel = 3'($urandom);
         rst = ($urandom_range(19, 0) == 0);
         tick();
      end
      rst = 1'b0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
